// File: rtl/vector_register_group_read_pkg.sv
// Shared types and default sizing for the vector register group read stage.
package vector_register_group_read_pkg;

  localparam int DEF_NUM_READ_PORTS   = 4;
  localparam int DEF_NUMBER_REGISTERS = 64;
  localparam int DEF_REGISTER_LENGTH  = 128;
  localparam int DEF_TAG_LENGTH       = $clog2(DEF_NUMBER_REGISTERS);
  localparam int DEF_MAX_LMUL_LOG2    = 3;

  typedef logic [DEF_TAG_LENGTH-1:0]      vreg_tag_t;
  typedef logic [DEF_REGISTER_LENGTH-1:0] vreg_data_t;

  typedef struct packed {
    logic [DEF_NUM_READ_PORTS-1:0][DEF_TAG_LENGTH-1:0] tags;
    logic [DEF_NUM_READ_PORTS-1:0]                     mask;
    logic [1:0]                                        lmul_log2;
  } read_group_request_t;

  typedef struct packed {
    logic [DEF_NUM_READ_PORTS-1:0]                          port_valid;
    logic [DEF_NUM_READ_PORTS-1:0][DEF_TAG_LENGTH-1:0]      tags;
    logic [DEF_NUM_READ_PORTS-1:0][DEF_REGISTER_LENGTH-1:0] data;
    logic [DEF_MAX_LMUL_LOG2-1:0]                           beat;
    logic                                                   last;
  } read_group_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rg_state_e;

  // Requested group exponent saturated at the largest supported group.
  function automatic int unsigned clamp_lmul(input int unsigned lmul,
                                             input int unsigned max_lmul);
    return (lmul > max_lmul) ? max_lmul : lmul;
  endfunction

endpackage

// File: rtl/vector_register_group_read_storage_array.sv
// Physical vector register file: NUM_READ_PORTS registered read ports, one
// write port, whole array cleared by reset.
// Build option VECTOR_READ_BYPASS_EN: a read that issues in the same cycle as a
// write to its address returns the write data (write-first); otherwise the
// read sees the old contents (read-first).
module vector_register_storage_array
  import vector_register_group_read_pkg::*;
#(
  parameter int NUM_READ_PORTS   = DEF_NUM_READ_PORTS,
  parameter int NUMBER_REGISTERS = DEF_NUMBER_REGISTERS,
  parameter int REGISTER_LENGTH  = DEF_REGISTER_LENGTH,
  parameter int TAG_LENGTH       = $clog2(NUMBER_REGISTERS)
) (
  input  logic                                             clock,
  input  logic                                             reset_n,
  input  logic                                             i_rd_en,
  input  logic [NUM_READ_PORTS-1:0]                        i_rd_port_en,
  input  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]        i_rd_addr,
  output logic [NUM_READ_PORTS-1:0][REGISTER_LENGTH-1:0]   o_rd_data,
  input  logic                                             i_wr_en,
  input  logic [TAG_LENGTH-1:0]                            i_wr_addr,
  input  logic [REGISTER_LENGTH-1:0]                       i_wr_data
);

  logic [NUMBER_REGISTERS-1:0][REGISTER_LENGTH-1:0] r_mem;
  logic [NUM_READ_PORTS-1:0][REGISTER_LENGTH-1:0]   r_rd_data;
  logic [NUM_READ_PORTS-1:0][REGISTER_LENGTH-1:0]   w_rd_val;

  // Single write port; writes land regardless of any read activity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_mem <= '0;
    else if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Per-port array lookup, optionally forwarding a same-cycle write.
  always_comb begin
    w_rd_val = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      w_rd_val[p] = r_mem[i_rd_addr[p]];
`ifdef VECTOR_READ_BYPASS_EN
      if (i_wr_en && (i_wr_addr == i_rd_addr[p])) w_rd_val[p] = i_wr_data;
`endif
    end
  end

  // Read registers capture only on issue, so a stalled beat stays a snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      for (int p = 0; p < NUM_READ_PORTS; p++)
        r_rd_data[p] <= i_rd_port_en[p] ? w_rd_val[p] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vector_register_group_read.sv
// Vector register group read stage: accepts one request carrying a base tag
// per read port plus a register-group size, then streams the group one
// register per beat over valid/ready. Owns the physical register storage.
// Build option VECTOR_READ_BYPASS_EN selects write-first forwarding in the
// storage array (default read-first).
module vector_register_group_read
  import vector_register_group_read_pkg::*;
#(
  parameter int NUM_READ_PORTS   = DEF_NUM_READ_PORTS,
  parameter int NUMBER_REGISTERS = DEF_NUMBER_REGISTERS,
  parameter int REGISTER_LENGTH  = DEF_REGISTER_LENGTH,
  parameter int TAG_LENGTH       = $clog2(NUMBER_REGISTERS),
  parameter int MAX_LMUL_LOG2    = DEF_MAX_LMUL_LOG2
) (
  input  logic                                           clock,
  input  logic                                           reset_n,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]      req_tags,
  input  logic [NUM_READ_PORTS-1:0]                      req_mask,
  input  logic [1:0]                                     req_lmul_log2,
  input  logic                                           wb_valid,
  input  logic [TAG_LENGTH-1:0]                          wb_tag,
  input  logic [REGISTER_LENGTH-1:0]                     wb_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [NUM_READ_PORTS-1:0]                      out_port_valid,
  output logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]      out_tags,
  output logic [NUM_READ_PORTS-1:0][REGISTER_LENGTH-1:0] out_data,
  output logic [MAX_LMUL_LOG2-1:0]                       out_beat,
  output logic                                           out_last
);

  rg_state_e                                  r_state;
  logic                                       r_req_ready;
  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]  r_base;
  logic [NUM_READ_PORTS-1:0]                  r_mask;
  logic [MAX_LMUL_LOG2-1:0]                   r_last_idx;
  logic [MAX_LMUL_LOG2-1:0]                   r_beat;
  logic                                       r_out_valid;
  logic [NUM_READ_PORTS-1:0]                  r_out_port_valid;
  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]  r_out_tags;
  logic [MAX_LMUL_LOG2-1:0]                   r_out_beat;
  logic                                       r_out_last;

  int unsigned                                w_lmul_eff;
  logic [MAX_LMUL_LOG2-1:0]                   w_req_last_idx;
  logic                                       w_issue;
  logic                                       w_issue_last;
  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]  w_rd_addr;
  logic [NUM_READ_PORTS-1:0][TAG_LENGTH-1:0]  w_rd_tags;

  // Group length is carried as the index of the final beat.
  assign w_lmul_eff     = clamp_lmul(32'(req_lmul_log2), MAX_LMUL_LOG2);
  assign w_req_last_idx = MAX_LMUL_LOG2'((1 << w_lmul_eff) - 1);

  // A beat issues whenever the output slot is empty or draining this cycle.
  assign w_issue      = (r_state == ST_BUSY) && (!r_out_valid || out_ready);
  assign w_issue_last = w_issue && (r_beat == r_last_idx);

  // Per-port address walks the group, wrapping at the tag width.
  always_comb begin
    w_rd_addr = '0;
    w_rd_tags = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      w_rd_addr[p] = r_base[p] + TAG_LENGTH'(r_beat);
      w_rd_tags[p] = r_mask[p] ? w_rd_addr[p] : '0;
    end
  end

  vector_register_storage_array #(
    .NUM_READ_PORTS   (NUM_READ_PORTS),
    .NUMBER_REGISTERS (NUMBER_REGISTERS),
    .REGISTER_LENGTH  (REGISTER_LENGTH),
    .TAG_LENGTH       (TAG_LENGTH)
  ) u_storage (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_rd_en      (w_issue),
    .i_rd_port_en (r_mask),
    .i_rd_addr    (w_rd_addr),
    .o_rd_data    (out_data),
    .i_wr_en      (wb_valid),
    .i_wr_addr    (wb_tag),
    .i_wr_data    (wb_data)
  );

  // Request FSM, beat counter and output slot sidecar (data lives in storage).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_req_ready      <= 1'b1;
      r_base           <= '0;
      r_mask           <= '0;
      r_last_idx       <= '0;
      r_beat           <= '0;
      r_out_valid      <= 1'b0;
      r_out_port_valid <= '0;
      r_out_tags       <= '0;
      r_out_beat       <= '0;
      r_out_last       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_out_valid      <= 1'b1;
        r_out_port_valid <= r_mask;
        r_out_tags       <= w_rd_tags;
        r_out_beat       <= r_beat;
        r_out_last       <= w_issue_last;
      end else if (out_ready) begin
        r_out_valid      <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_base      <= req_tags;
            r_mask      <= req_mask;
            r_last_idx  <= w_req_last_idx;
            r_beat      <= '0;
            r_state     <= ST_BUSY;
            r_req_ready <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_issue) begin
            r_beat <= r_beat + MAX_LMUL_LOG2'(1);
            if (w_issue_last) begin
              r_state     <= ST_IDLE;
              r_req_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign out_valid      = r_out_valid;
  assign out_port_valid = r_out_port_valid;
  assign out_tags       = r_out_tags;
  assign out_beat       = r_out_beat;
  assign out_last       = r_out_last;

endmodule

// File: tb/tb_vector_register_group_read.sv
// Self-checking bench for vector_register_group_read with a behavioural
// register-file model. A second instance with MAX_LMUL_LOG2=2 covers clamping.
module tb_vector_register_group_read;

  localparam int NP = 4;
  localparam int NR = 64;
  localparam int RL = 128;
  localparam int TL = 6;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [NP-1:0][TL-1:0]  req_tags;
  logic [NP-1:0]          req_mask;
  logic [1:0]             req_lmul_log2;
  logic                   wb_valid;
  logic [TL-1:0]          wb_tag;
  logic [RL-1:0]          wb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NP-1:0]          out_port_valid;
  logic [NP-1:0][TL-1:0]  out_tags;
  logic [NP-1:0][RL-1:0]  out_data;
  logic [2:0]             out_beat;
  logic                   out_last;

  logic                   m2_req_ready;
  logic                   m2_out_valid;
  logic [NP-1:0]          m2_out_port_valid;
  logic [NP-1:0][TL-1:0]  m2_out_tags;
  logic [NP-1:0][RL-1:0]  m2_out_data;
  logic [1:0]             m2_out_beat;
  logic                   m2_out_last;

  logic [RL-1:0]          mem [NR];
  int                     errors = 0;
  int                     checks = 0;

  always #5 clock = ~clock;

  vector_register_group_read dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tags(req_tags),
    .req_mask(req_mask), .req_lmul_log2(req_lmul_log2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_port_valid(out_port_valid),
    .out_tags(out_tags), .out_data(out_data), .out_beat(out_beat), .out_last(out_last)
  );

  vector_register_group_read #(.MAX_LMUL_LOG2(2)) dut_m2 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(m2_req_ready), .req_tags(req_tags),
    .req_mask(req_mask), .req_lmul_log2(req_lmul_log2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .out_valid(m2_out_valid), .out_ready(out_ready), .out_port_valid(m2_out_port_valid),
    .out_tags(m2_out_tags), .out_data(m2_out_data), .out_beat(m2_out_beat), .out_last(m2_out_last)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [RL-1:0] rand_reg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mem[i] = '0;
  endtask

  task automatic write_reg(input int tag, input logic [RL-1:0] d);
    wb_valid = 1'b1;
    wb_tag   = TL'(tag);
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
    mem[tag] = d;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_model();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Issue one request and consume the whole group, checking every presented beat.
  task automatic run_group(input logic [NP-1:0][TL-1:0] tags, input logic [NP-1:0] mask,
                           input logic [1:0] lmul, input int stall_beat, input int stall_cycles,
                           input bit rnd_ready, input string nm);
    int n, got, held, cyc, ti;
    logic [NP-1:0][RL-1:0] ed;
    logic [NP-1:0][TL-1:0] et;
    n = 1 << ((lmul > 2'd3) ? 3 : int'(lmul));
    cyc = 0;
    while (!req_ready && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle-wait: req_ready=%b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_tags = tags; req_mask = mask; req_lmul_log2 = lmul;
    tick();
    req_valid = 1'b0;
    got = 0; held = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else if (got == stall_beat && held < stall_cycles && out_valid) begin
        out_ready = 1'b0; held++;
      end else out_ready = 1'b1;
      if (out_valid) begin
        ed = '0; et = '0;
        for (int p = 0; p < NP; p++)
          if (mask[p]) begin
            ti = (int'(tags[p]) + got) % NR;
            et[p] = TL'(ti);
            ed[p] = mem[ti];
          end
        checks++;
        if (out_data !== ed) begin
          errors++; $display("FAIL %s data beat %0d: got %h want %h", nm, got, out_data, ed);
        end
        checks++;
        if (out_tags !== et || out_beat !== 3'(got) || out_last !== (got == n - 1) ||
            out_port_valid !== mask) begin
          errors++;
          $display("FAIL %s ctrl beat %0d: got tags=%h beat=%0d last=%b pv=%b want tags=%h beat=%0d last=%b pv=%b",
                   nm, got, out_tags, out_beat, out_last, out_port_valid, et, got, (got == n - 1), mask);
        end
        if (out_ready) got++;
      end
      tick(); cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (got != n) begin
      errors++; $display("FAIL %s beat count: got %0d want %0d", nm, got, n);
    end
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s post-group: out_valid=%b req_ready=%b want 0/1", nm, out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_tags = '0; req_mask = '0; req_lmul_log2 = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; out_ready = 1'b1;
    clear_model();
    #12;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_beat !== 3'd0 ||
        out_port_valid !== '0 || out_tags !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rr=%b ov=%b last=%b beat=%0d pv=%b tags=%h want 1 0 0 0 0 0",
               req_ready, out_valid, out_last, out_beat, out_port_valid, out_tags);
    end
    checks++;
    if (m2_req_ready !== 1'b1 || m2_out_valid !== 1'b0 || m2_out_last !== 1'b0 || m2_out_beat !== 2'd0 ||
        m2_out_port_valid !== '0 || m2_out_tags !== '0 || m2_out_data !== '0) begin
      errors++; $display("FAIL reset_outputs_m2: got rr=%b ov=%b want 1 0", m2_req_ready, m2_out_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    run_group({6'd33, 6'd17, 6'd8, 6'd1}, 4'hF, 2'd1, -1, 0, 1'b0, "reset_storage_zero");
  endtask

  task automatic test_single();
    write_reg(5, {16{8'hA5}});
    run_group({6'd9, 6'd7, 6'd5, 6'd0}, 4'b0010, 2'd0, -1, 0, 1'b0, "single_lmul1");
  endtask

  task automatic test_wrap();
    logic [NP-1:0][TL-1:0] t;
    for (int i = 0; i < 8; i++) write_reg((60 + i) % NR, rand_reg());
    t = {6'($urandom), 6'($urandom), 6'($urandom), 6'd60};
    run_group(t, {3'($urandom), 1'b1}, 2'd3, -1, 0, 1'b0, "wrap_lmul8");
  endtask

  task automatic test_backpressure();
    for (int i = 20; i < 24; i++) write_reg(i, rand_reg());
    run_group({6'd22, 6'd21, 6'd40, 6'd20}, 4'b1011, 2'd2, 1, 3, 1'b0, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) write_reg($urandom_range(0, NR - 1), rand_reg());
    for (int g = 0; g < 6; g++)
      run_group({6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom)},
                4'($urandom), 2'($urandom), -1, 0, 1'b1, "random_group");
  endtask

  task automatic test_same_cycle_write();
    logic [RL-1:0] oldd, newd, expd;
    int cyc;
    oldd = rand_reg();
    newd = ~oldd;
    write_reg(2, oldd);
    cyc = 0;
    while (!req_ready && cyc < 50) begin tick(); cyc++; end
    req_valid = 1'b1; req_tags = {6'd0, 6'd0, 6'd0, 6'd2}; req_mask = 4'b0001; req_lmul_log2 = 2'd0;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 6'd2; wb_data = newd;
    tick();
    wb_valid = 1'b0;
`ifdef VECTOR_READ_BYPASS_EN
    expd = newd;
`else
    expd = oldd;
`endif
    mem[2] = newd;
    checks++;
    if (out_valid !== 1'b1 || out_data[0] !== expd) begin
      errors++; $display("FAIL same_cycle_write: got ov=%b d=%h want 1 %h", out_valid, out_data[0], expd);
    end
    tick();
    run_group({6'd0, 6'd0, 6'd0, 6'd2}, 4'b0001, 2'd0, -1, 0, 1'b0, "after_write");
  endtask

  task automatic test_reset_mid_group();
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 50) begin tick(); cyc++; end
    req_valid = 1'b1; req_tags = {6'd1, 6'd0, 6'd61, 6'd60}; req_mask = 4'hF; req_lmul_log2 = 2'd3;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!(out_valid && out_beat == 3'd3) && cyc < 30) begin tick(); cyc++; end
    checks++;
    if (!(out_valid && out_beat == 3'd3)) begin
      errors++; $display("FAIL reset_mid reach beat3: got ov=%b beat=%0d want 1 3", out_valid, out_beat);
    end
    reset_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_data !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got ov=%b rr=%b want 0 1", out_valid, req_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
    run_group({6'd1, 6'd0, 6'd61, 6'd60}, 4'hF, 2'd1, -1, 0, 1'b0, "reset_mid_storage");
  endtask

  task automatic test_clamp();
    int n8, n4, cyc;
    apply_reset();
    req_valid = 1'b1; req_tags = {6'd4, 6'd3, 6'd2, 6'd1}; req_mask = 4'hF; req_lmul_log2 = 2'd3;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    n8 = 0; n4 = 0; cyc = 0;
    while (cyc < 20) begin
      if (m2_out_valid) begin
        checks++;
        if (m2_out_beat !== 2'(n4) || m2_out_last !== (n4 == 3)) begin
          errors++; $display("FAIL clamp beat: got beat=%0d last=%b want %0d %b", m2_out_beat, m2_out_last, n4, (n4 == 3));
        end
        n4++;
      end
      if (out_valid) n8++;
      tick(); cyc++;
    end
    checks++;
    if (n4 != 4 || m2_req_ready !== 1'b1) begin
      errors++; $display("FAIL clamp count: got %0d rr=%b want 4 1", n4, m2_req_ready);
    end
    checks++;
    if (n8 != 8) begin
      errors++; $display("FAIL lmul8 count: got %0d want 8", n8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_random();
    test_same_cycle_write();
    test_reset_mid_group();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
